// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the single-port RAM bus initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_bus_pkg;

   localparam int ADDR_W_DEFAULT = 12;
   localparam int DATA_W_DEFAULT = 16;

   // read_not_write encoding as seen on the RAM pins
   localparam logic RNW_READ  = 1'b1;
   localparam logic RNW_WRITE = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      TURN  = 2'd3
   } bus_state_t;

endpackage

// File: rtl/mem_bus_tristate.sv
// Output-enable pad for the bidirectional RAM data bus.
// Latency: combinational in both directions.
// Backpressure: none; oe alone decides who owns the bus.
module mem_bus_tristate #(
   parameter int W = 16
) (
   input  logic         oe,
   input  logic [W-1:0] dout,
   output logic [W-1:0] din,
   inout  wire  [W-1:0] bus
);

   assign bus = oe ? dout : {W{1'bz}};
   assign din = bus;

endmodule

// File: rtl/mem_bus_master.sv
// Initiator for the shared single-port RAM: one request at a time, write turnaround.
// Latency: read READ_LATENCY+1 cycles, write 2 cycles, accept edge to rsp_valid.
// Backpressure: req_ready only in IDLE; a pending request waits until the bus cycle ends.
module mem_bus_master
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEFAULT,
   parameter int DATA_W       = DATA_W_DEFAULT,
   parameter int READ_LATENCY = 1   // must be >= 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] address,
   output logic              read_not_write,
   inout  wire  [DATA_W-1:0] data
);

   localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

   bus_state_t        state;
   logic              rnw_q;     // single source for both read_not_write and the pad enable
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] din;
   logic              oe;

   assign req_ready      = (state == IDLE);
   assign read_not_write = rnw_q;
   assign oe             = (rnw_q == RNW_WRITE);

   mem_bus_tristate #(.W(DATA_W)) u_pad (
      .oe   (oe),
      .dout (wdata_q),
      .din  (din),
      .bus  (data)
   );

   // Bus sequencer: accept, read wait/sample/respond, one write cycle, one turnaround cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         address   <= '0;
         rnw_q     <= RNW_READ;
         wdata_q   <= '0;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               // address is only touched on accept so the bus stays quiet while idle
               if (req_valid) begin
                  address <= req_addr;
                  wdata_q <= req_wdata;
                  cnt     <= '0;
                  if (req_write) begin
                     state <= WRITE;
                     rnw_q <= RNW_WRITE;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               // the cycle carrying rsp_valid is the last one spent in READ
               if (rsp_valid) begin
                  state <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  rsp_rdata <= din;
                  rsp_valid <= 1'b1;
                  rsp_write <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WRITE: begin
               // RAM captures on this edge; release the bus on the same edge
               state     <= TURN;
               rnw_q     <= RNW_READ;
               rsp_valid <= 1'b1;
               rsp_write <= 1'b1;
            end
            TURN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               rnw_q <= RNW_READ;
            end
         endcase
      end
   end

endmodule
